// File: rtl/regfile_dump_ctrl.sv
// Register-file debug dumper: on a rising halt trigger, reads registers 0..NUM_REGS-1
// through the debug port and streams them out, followed by an XOR checksum beat.
module regfile_dump_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  output logic [ADDR_W-1:0] regfile_addr,
  input  logic [DATA_W-1:0] regfile_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    CSUM
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [ADDR_W-1:0] index_reg, index_next;
  logic              last_reg, last_next;
  logic              valid_reg, valid_next;
  logic              done_reg, done_next;
  logic [DATA_W-1:0] checksum_reg, checksum_next;
  logic              trig_q;

  logic start;
  logic handshake;

  // Only a low-to-high transition of the level trigger starts a dump.
  assign start     = trigger & ~trig_q;
  assign handshake = valid_reg & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      data_reg     <= '0;
      index_reg    <= '0;
      last_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      done_reg     <= 1'b0;
      checksum_reg <= '0;
      trig_q       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      index_reg    <= index_next;
      last_reg     <= last_next;
      valid_reg    <= valid_next;
      done_reg     <= done_next;
      checksum_reg <= checksum_next;
      trig_q       <= trigger;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    data_next     = data_reg;
    index_next    = index_reg;
    last_next     = last_reg;
    valid_next    = valid_reg;
    done_next     = 1'b0;
    checksum_next = checksum_reg;

    unique case (state_reg)
      IDLE: begin
        addr_next = '0;
        if (start) begin
          checksum_next = '0;
          state_next    = READ;
        end
      end

      READ: begin
        data_next     = regfile_data;
        index_next    = addr_reg;
        checksum_next = checksum_reg ^ regfile_data;
        valid_next    = 1'b1;
        state_next    = SEND;
      end

      SEND: begin
        if (handshake) begin
          if (addr_reg == LAST_ADDR) begin
            // Checksum already includes the value just sent.
            data_next  = checksum_reg;
            index_next = '0;
            last_next  = 1'b1;
            state_next = CSUM;
          end else begin
            valid_next = 1'b0;
            addr_next  = addr_reg + 1'b1;
            state_next = READ;
          end
        end
      end

      CSUM: begin
        if (handshake) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          done_next  = 1'b1;
          addr_next  = '0;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign regfile_addr = addr_reg;
  assign out_valid    = valid_reg;
  assign out_data     = data_reg;
  assign out_index    = index_reg;
  assign out_last     = last_reg;
  assign busy         = (state_reg != IDLE);
  assign done         = done_reg;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench for regfile_dump_ctrl: a 32-register instance and a 2-register instance.
module tb_regfile_dump_ctrl;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  index;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger1, trigger2;
  logic        ready1, ready2;
  logic [4:0]  rf_addr1, rf_addr2;
  logic [31:0] rf_data1, rf_data2;
  logic        valid1, valid2, last1, last2, busy1, busy2, done1, done2;
  logic [31:0] data1, data2;
  logic [4:0]  index1, index2;

  logic [31:0] regs1 [0:31];
  logic [31:0] exp_regs1 [0:31];
  logic [31:0] regs2 [0:1];

  beat_t q1[$];
  beat_t q2[$];

  int tests_run = 0;
  int fails = 0;
  int beats1 = 0, beats2 = 0;
  int done_cnt1 = 0, done_cnt2 = 0;

  always #5 clk = ~clk;

  assign rf_data1 = regs1[rf_addr1];
  assign rf_data2 = regs2[rf_addr2[0]];

  regfile_dump_ctrl #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut1 (
    .clk(clk), .rst(rst), .trigger(trigger1),
    .regfile_addr(rf_addr1), .regfile_data(rf_data1),
    .out_valid(valid1), .out_ready(ready1), .out_data(data1),
    .out_index(index1), .out_last(last1), .busy(busy1), .done(done1)
  );

  regfile_dump_ctrl #(.NUM_REGS(2), .ADDR_W(5), .DATA_W(32)) dut2 (
    .clk(clk), .rst(rst), .trigger(trigger2),
    .regfile_addr(rf_addr2), .regfile_data(rf_data2),
    .out_valid(valid2), .out_ready(ready2), .out_data(data2),
    .out_index(index2), .out_last(last2), .busy(busy2), .done(done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump1();
    logic [31:0] csum;
    csum = '0;
    for (int i = 0; i < 32; i++) begin
      q1.push_back('{data: exp_regs1[i], index: 5'(i), last: 1'b0});
      csum ^= exp_regs1[i];
    end
    q1.push_back('{data: csum, index: 5'd0, last: 1'b1});
  endtask

  task automatic wait_done(input int which, input int budget, output int cycles);
    bit found;
    found  = 0;
    cycles = 0;
    while (!found && cycles < budget) begin
      tick();
      cycles++;
      if ((which == 1) ? done1 : done2) found = 1;
    end
    if (!found) check($sformatf("dut%0d done timeout", which), 32'd0, 32'd1);
  endtask

  // Monitor for the 32-register instance: pops expected beats and checks hold stability.
  logic        hold1 = 1'b0, prev_done1 = 1'b0;
  beat_t       held1;
  always @(negedge clk) begin
    if (rst) begin
      hold1      = 1'b0;
      prev_done1 = 1'b0;
    end else begin
      if (hold1) begin
        check("dut1 held data", data1, held1.data);
        check("dut1 held index", 32'(index1), 32'(held1.index));
      end
      hold1 = valid1 && !ready1;
      held1 = '{data: data1, index: index1, last: last1};
      if (valid1 && ready1) begin
        beats1++;
        $display("[TB] dut1 beat idx=%0d data=%h last=%b", index1, data1, last1);
        if (q1.size() == 0) begin
          check("dut1 unexpected beat", 32'd1, 32'd0);
        end else begin
          beat_t e;
          e = q1.pop_front();
          check("dut1 beat data", data1, e.data);
          check("dut1 beat index", 32'(index1), 32'(e.index));
          check("dut1 beat last", 32'(last1), 32'(e.last));
        end
      end
      if (done1) begin
        done_cnt1++;
        check("dut1 done single pulse", 32'(prev_done1), 32'd0);
      end
      prev_done1 = done1;
    end
  end

  // Monitor for the 2-register instance.
  logic prev_done2 = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_done2 = 1'b0;
    end else begin
      if (valid2 && ready2) begin
        beats2++;
        $display("[TB] dut2 beat idx=%0d data=%h last=%b", index2, data2, last2);
        if (q2.size() == 0) begin
          check("dut2 unexpected beat", 32'd1, 32'd0);
        end else begin
          beat_t e;
          e = q2.pop_front();
          check("dut2 beat data", data2, e.data);
          check("dut2 beat index", 32'(index2), 32'(e.index));
          check("dut2 beat last", 32'(last2), 32'(e.last));
        end
      end
      if (done2) begin
        done_cnt2++;
        check("dut2 done single pulse", 32'(prev_done2), 32'd0);
      end
      prev_done2 = done2;
    end
  end

  initial begin
    int cyc;
    int base;
    int dc;

    rst      = 1'b1;
    trigger1 = 1'b1;
    trigger2 = 1'b0;
    ready1   = 1'b1;
    ready2   = 1'b1;
    for (int i = 0; i < 32; i++) regs1[i] = 32'(i) * 32'h1111_1111;
    regs2[0] = 32'hFFFF_FFFF;
    regs2[1] = 32'hFFFF_FFFF;
    exp_regs1 = regs1;

    // Reset held with trigger high: everything quiet.
    repeat (3) tick();
    check("reset regfile_addr", 32'(rf_addr1), 32'd0);
    check("reset out_valid", 32'(valid1), 32'd0);
    check("reset out_data", data1, 32'd0);
    check("reset out_index", 32'(index1), 32'd0);
    check("reset out_last", 32'(last1), 32'd0);
    check("reset busy", 32'(busy1), 32'd0);
    check("reset done", 32'(done1), 32'd0);

    // Release with trigger still high: one full dump, done 2*32+2 cycles later.
    push_dump1();
    rst = 1'b0;
    wait_done(1, 300, cyc);
    check("dut1 dump latency", 32'(cyc), 32'd66);
    check("dut1 scoreboard drained", 32'(q1.size()), 32'd0);

    // Keep trigger high for 100 more cycles: no second dump.
    repeat (100) tick();
    check("held trigger one dump", 32'(done_cnt1), 32'd1);
    check("held trigger beat count", 32'(beats1), 32'd33);
    trigger1 = 1'b0;
    tick();

    // Backpressure: stall beat 7 for 5 cycles.
    push_dump1();
    trigger1 = 1'b1;
    tick();
    trigger1 = 1'b0;
    begin
      bit stalled;
      stalled = 0;
      cyc = 0;
      while (!done1 && cyc < 400) begin
        if (!stalled && valid1 && !last1 && index1 == 5'd7) begin
          stalled = 1;
          ready1  = 1'b0;
          repeat (5) tick();
          ready1  = 1'b1;
        end
        tick();
        cyc++;
      end
      check("backpressure stall applied", 32'(stalled), 32'd1);
    end
    tick();
    check("backpressure scoreboard drained", 32'(q1.size()), 32'd0);
    check("backpressure done count", 32'(done_cnt1), 32'd2);

    // Second trigger edge while busy is ignored.
    push_dump1();
    trigger1 = 1'b1;
    tick();
    trigger1 = 1'b0;
    repeat (10) tick();
    trigger1 = 1'b1;
    tick();
    trigger1 = 1'b0;
    wait_done(1, 300, cyc);
    repeat (80) tick();
    check("busy trigger done count", 32'(done_cnt1), 32'd3);
    check("busy trigger beat count", 32'(beats1), 32'd99);

    // Reset after beat 10: output drops at once, no done.
    push_dump1();
    base = beats1;
    dc   = done_cnt1;
    trigger1 = 1'b1;
    tick();
    trigger1 = 1'b0;
    cyc = 0;
    while (beats1 < base + 11 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("reached beat 10", 32'(beats1 - base), 32'd11);
    #2;
    rst = 1'b1;
    #1;
    check("mid reset out_valid", 32'(valid1), 32'd0);
    check("mid reset busy", 32'(busy1), 32'd0);
    check("mid reset regfile_addr", 32'(rf_addr1), 32'd0);
    q1.delete();
    tick();
    rst = 1'b0;
    repeat (80) tick();
    check("mid reset no done", 32'(done_cnt1), 32'(dc));

    // Fresh dump with new contents; register 31 changes during the dump.
    for (int i = 0; i < 32; i++) regs1[i] = 32'hDEAD_0000 | 32'(i * 3);
    exp_regs1 = regs1;
    exp_regs1[31] = 32'h0BAD_CAFE;
    push_dump1();
    trigger1 = 1'b1;
    tick();
    trigger1 = 1'b0;
    repeat (10) tick();
    regs1[31] = 32'h0BAD_CAFE;
    wait_done(1, 300, cyc);
    tick();
    check("restart scoreboard drained", 32'(q1.size()), 32'd0);
    check("restart done count", 32'(done_cnt1), 32'(dc + 1));

    // Two-register instance: FFFFFFFF twice, checksum 0.
    q2.push_back('{data: 32'hFFFF_FFFF, index: 5'd0, last: 1'b0});
    q2.push_back('{data: 32'hFFFF_FFFF, index: 5'd1, last: 1'b0});
    q2.push_back('{data: 32'h0000_0000, index: 5'd0, last: 1'b1});
    trigger2 = 1'b1;
    wait_done(2, 100, cyc);
    check("dut2 dump latency", 32'(cyc), 32'd6);
    trigger2 = 1'b0;
    repeat (20) tick();
    check("dut2 scoreboard drained", 32'(q2.size()), 32'd0);
    check("dut2 done count", 32'(done_cnt2), 32'd1);
    check("dut2 beat count", 32'(beats2), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
